// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: opcode from the IR in, strobes and decoded
// instruction-class flags out, plus status for the front panel.
interface multicycle_controller_if #(
  parameter int OPCODE_W = 3,
  parameter int ALUSEL_W = 2
);
  logic [OPCODE_W-1:0] opcode;
  logic                isLoad, isStore, isAdd, isSubtract, isExternal;
  logic                isAnd, isOr;
  logic                D_rd, D_wr;
  logic                IR_ld, PC_ld, wr_en;
  logic [ALUSEL_W-1:0] ALUSel;
  logic                run_mode, busy, halted, illegal;

  // controller side
  modport master (
    input  opcode,
    output isLoad, isStore, isAdd, isSubtract, isExternal, isAnd, isOr,
    output D_rd, D_wr, IR_ld, PC_ld, wr_en, ALUSel,
    output run_mode, busy, halted, illegal
  );

  // datapath / IR side
  modport slave (
    output opcode,
    input  isLoad, isStore, isAdd, isSubtract, isExternal, isAnd, isOr,
    input  D_rd, D_wr, IR_ld, PC_ld, wr_en, ALUSel,
    input  run_mode, busy, halted, illegal
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle control unit: FETCH -> DECODE -> EXEC -> WB per instruction,
// with single-step / free-run modes, memory-latency hold in EXEC, HALT and a
// sticky illegal-opcode flag. All strobes are Moore outputs of the state and
// the latched opcode, so an async reset drops them immediately.
module multicycle_controller #(
  parameter int OPCODE_W = 3,  // >= 3; values >= 8 are illegal
  parameter int ALUSEL_W = 2,  // >= 2
  parameter int MEM_LAT  = 2   // 1..15 cycles of D_rd/D_wr
) (
  input  logic clk,
  input  logic reset,
  input  logic leftBtnDebounce,
  input  logic rightBtnDebounce,
  multicycle_controller_if.master bus
);

  typedef enum logic [2:0] {
    st_idle, st_fetch, st_decode, st_exec, st_wb, st_halt
  } state_t;

  state_t     state, nxt;
  logic       left_q, left_p, right_q, right_p;
  logic       left_rise, right_rise;
  logic       run_mode_q, illegal_q, set_illegal;
  logic [2:0] op_q;
  logic [3:0] cnt;
  logic       cnt_last, mem_op, op_hi, in_ex;

  // Any opcode bit above the 3-bit map makes the instruction illegal.
  if (OPCODE_W > 3) begin : g_hi
    assign op_hi = |bus.opcode[OPCODE_W-1:3];
  end else begin : g_nohi
    assign op_hi = 1'b0;
  end

  assign left_rise  = left_q & ~left_p;
  assign right_rise = right_q & ~right_p;
  assign mem_op     = (op_q[2:1] == 2'b00);       // LOAD or STORE
  assign cnt_last   = (cnt == 4'(MEM_LAT - 1));
  assign in_ex      = (state == st_exec) || (state == st_wb);

  // Button synchroniser stage plus previous-value register for edge detect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      left_q  <= 1'b0;
      left_p  <= 1'b0;
      right_q <= 1'b0;
      right_p <= 1'b0;
    end else begin
      left_q  <= leftBtnDebounce;
      left_p  <= left_q;
      right_q <= rightBtnDebounce;
      right_p <= right_q;
    end
  end

  // Mode toggle (frozen in HALT) and sticky illegal flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_mode_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      if (right_rise && state != st_halt) run_mode_q <= ~run_mode_q;
      if (set_illegal) illegal_q <= 1'b1;
    end
  end

  // Opcode latched in DECODE; flags in EXEC/WB come from this copy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  op_q <= '0;
    else if (state == st_decode) op_q <= bus.opcode[2:0];
  end

  // Memory-latency counter: runs only while a LOAD/STORE sits in EXEC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                          cnt <= '0;
    else if (state == st_exec && mem_op && !cnt_last)    cnt <= cnt + 4'd1;
    else                                                 cnt <= '0;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= st_idle;
    else        state <= nxt;
  end

  // Next-state and output decode.
  always_comb begin
    nxt            = state;
    set_illegal    = 1'b0;
    bus.isLoad     = 1'b0;
    bus.isStore    = 1'b0;
    bus.isAdd      = 1'b0;
    bus.isSubtract = 1'b0;
    bus.isAnd      = 1'b0;
    bus.isOr       = 1'b0;
    bus.isExternal = 1'b0;
    bus.ALUSel     = '0;
    bus.IR_ld      = (state == st_fetch);
    bus.PC_ld      = (state == st_decode);
    bus.D_rd       = (state == st_exec) && (op_q == 3'b000);
    bus.D_wr       = (state == st_exec) && (op_q == 3'b001);
    bus.wr_en      = (state == st_wb);   // WB is only reached by writing ops
    bus.run_mode   = run_mode_q;
    bus.illegal    = illegal_q;
    bus.halted     = (state == st_halt);
    bus.busy       = (state != st_idle) && (state != st_halt);

    case (state)
      st_idle:   if (run_mode_q || left_rise) nxt = st_fetch;
      st_fetch:  nxt = st_decode;
      st_decode: begin
        if (op_hi) begin
          set_illegal = 1'b1;
          nxt         = st_idle;
        end else if (bus.opcode[2:0] == 3'b111) begin
          nxt = st_halt;
        end else begin
          nxt = st_exec;
        end
      end
      st_exec: begin
        if (!mem_op)                nxt = st_wb;
        else if (cnt_last) begin
          if (op_q == 3'b000)       nxt = st_wb;
          else                      nxt = run_mode_q ? st_fetch : st_idle;
        end
      end
      st_wb:     nxt = run_mode_q ? st_fetch : st_idle;
      st_halt:   nxt = st_halt;
      default:   nxt = st_idle;
    endcase

    if (in_ex) begin
      case (op_q)
        3'b000: bus.isLoad = 1'b1;
        3'b001: bus.isStore = 1'b1;
        3'b010: begin bus.isAdd = 1'b1;      bus.ALUSel = ALUSEL_W'(2'd0); end
        3'b011: begin bus.isSubtract = 1'b1; bus.ALUSel = ALUSEL_W'(2'd1); end
        3'b100: begin bus.isAnd = 1'b1;      bus.ALUSel = ALUSEL_W'(2'd2); end
        3'b101: begin bus.isOr = 1'b1;       bus.ALUSel = ALUSEL_W'(2'd3); end
        3'b110: bus.isExternal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
